lfsr_burst_ctrl: RTL and testbench

Command-driven sequencer for a 32-bit Fibonacci PRBS generator using taps 32, 22, 2 and 1.
- Accepts a seed plus a word count over a valid/ready command port.
- Loads the LFSR and streams exactly that many successive LFSR states over a valid/ready output port with a last flag, then signals completion.
- Sits between the test/BIST control logic and any PRBS consumer (pattern generator, scrambler seeding, memory test).

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr32_core.sv | 25 ++
 rtl/lfsr_burst_ctrl.sv | 123 ++++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, constants and next-state function for the 32-bit Fibonacci PRBS
// generator (taps 32, 22, 2, 1) and its burst controller.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_TAP_MASK     = 32'h80200003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h00000001;

    // Feedback is the parity of the tapped bits, shifted in at the LSB.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr32_core.sv
// 32-bit LFSR register with reset > load > step priority.
module lfsr32_core
    import lfsr_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Command-driven burst sequencer: loads a seed, streams a counted run of LFSR
// states over a valid/ready port, then pulses done (with aborted on early exit).
module lfsr_burst_ctrl
    import lfsr_pkg::*;
#(
    parameter int          CNT_W        = 16,
    parameter logic [31:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_seed,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             seed_fixed
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             handshake;
    logic             seed_zero;
    logic [31:0]      load_val;
    logic             last_word;

    assign accept    = cmd_valid & cmd_ready;
    assign handshake = out_valid & out_ready;
    assign seed_zero = (cmd_seed == 32'd0);
    assign load_val  = seed_zero ? DEFAULT_SEED : cmd_seed;
    assign last_word = (remaining == CNT_W'(1));

    lfsr32_core #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (load_val),
        .step     (handshake),
        .state    (out_data)
    );

    // Outputs are registered alongside the state so they change only at the
    // edge where the state transition happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            cmd_ready  <= 1'b1;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            seed_fixed <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        remaining  <= cmd_count;
                        seed_fixed <= seed_zero;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (cmd_count != '0) begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                            out_last  <= (cmd_count == CNT_W'(1));
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (handshake && remaining != '0) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                    // A final-word handshake wins over a coincident abort.
                    if (handshake && last_word) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end else if (abort) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                    end else if (handshake) begin
                        out_last <= (remaining == CNT_W'(2));
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Randomized and directed bench for lfsr_burst_ctrl against a word-list model
// built from the PRBS recurrence and the burst/abort rules.
module tb_lfsr_burst_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_seed;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             seed_fixed;

    int checks   = 0;
    int failures = 0;
    logic [31:0] gotWords[$];

    lfsr_burst_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_SEED (32'h00000001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_seed   (cmd_seed),
        .cmd_count  (cmd_count),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .seed_fixed (seed_fixed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] refStep(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] seed,
                                 input logic [CNT_W-1:0] count, input logic ready,
                                 input logic ab);
        cmd_valid = valid;
        cmd_seed  = seed;
        cmd_count = count;
        out_ready = ready;
        abort     = ab;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full burst: accept, stream with random back-pressure, optional abort
    // on word abortAt (1-based), stall the first word for stallFirst cycles.
    task automatic runBurst(input logic [31:0] seed, input int count, input int readyPct,
                            input int abortAt, input int stallFirst);
        logic [31:0] expState;
        int          words;
        int          budget;
        int          stalls;
        bit          ready;
        bit          ab;
        bit          modelEnded;
        bit          abortedExp;

        budget = 0;
        while (!cmd_ready && budget < 10) begin
            tick();
            budget++;
        end
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        gotWords.delete();

        applyStimulus(1'b1, seed, count[CNT_W-1:0], 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, '0, 1'b0, 1'b0);
        checkOutput("seed_fixed_accept", seed_fixed, seed == 32'd0);
        checkOutput("busy_accept", busy, 1);
        checkOutput("cmd_ready_busy", cmd_ready, 0);

        expState   = (seed == 32'd0) ? 32'h00000001 : seed;
        words      = 0;
        stalls     = 0;
        budget     = 0;
        modelEnded = (count == 0);
        abortedExp = 1'b0;

        while (!done && budget < 20 * count + 20) begin
            if (modelEnded) begin
                checkOutput("done_timing", done, 1);
                break;
            end
            checkOutput("out_valid", out_valid, 1);
            checkOutput("out_data", out_data, expState);
            checkOutput("out_last", out_last, words == count - 1);
            ready = ($urandom_range(0, 99) < readyPct);
            if (words == 0 && stalls < stallFirst) begin
                ready = 1'b0;
                stalls++;
            end
            ab = (abortAt != 0) && (words + 1 == abortAt);
            applyStimulus(1'b0, 32'd0, '0, ready, ab);
            if (ready) gotWords.push_back(out_data);
            tick();
            if (ready) begin
                expState = refStep(expState);
                words++;
            end
            if (words == count) modelEnded = 1'b1;
            if (ab) begin
                modelEnded = 1'b1;
                abortedExp = !(ready && words == count);
            end
            budget++;
        end
        applyStimulus(1'b0, 32'd0, '0, 1'b0, 1'b0);

        checkOutput("done_pulse", done, 1);
        checkOutput("aborted_pulse", aborted, abortedExp);
        checkOutput("out_valid_done", out_valid, 0);
        checkOutput("out_last_done", out_last, 0);
        checkOutput("out_data_after", out_data, expState);
        checkOutput("cmd_ready_done", cmd_ready, 0);
        checkOutput("seed_fixed_sticky", seed_fixed, seed == 32'd0);
        tick();
        checkOutput("done_clear", done, 0);
        checkOutput("aborted_clear", aborted, 0);
        checkOutput("cmd_ready_back", cmd_ready, 1);
        checkOutput("busy_clear", busy, 0);
    endtask

    initial begin
        logic [31:0] seed;
        int          count;
        int          pct;
        int          abortAt;

        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, '0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_seed_fixed", seed_fixed, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_out_data", out_data, 32'h00000001);
        reset = 1'b0;
        tick();
        checkOutput("idle_out_valid", out_valid, 0);

        $display("[TB] directed: seed 1 count 3");
        runBurst(32'h00000001, 3, 100, 0, 0);
        checkOutput("seq_len", gotWords.size(), 3);
        if (gotWords.size() == 3) begin
            checkOutput("seq_w0", gotWords[0], 32'h00000001);
            checkOutput("seq_w1", gotWords[1], 32'h00000003);
            checkOutput("seq_w2", gotWords[2], 32'h00000006);
        end

        $display("[TB] directed: zero seed");
        runBurst(32'h00000000, 1, 100, 0, 0);
        checkOutput("zero_seed_word", gotWords.size() > 0 ? gotWords[0] : 32'hFFFFFFFF, 32'h00000001);
        runBurst(32'h00000005, 2, 100, 0, 0);

        $display("[TB] directed: count 0");
        runBurst(32'h12345678, 0, 100, 0, 0);

        $display("[TB] directed: stall on first word");
        runBurst(32'h00000001, 3, 100, 0, 4);
        checkOutput("stall_len", gotWords.size(), 3);
        if (gotWords.size() == 3) begin
            checkOutput("stall_w0", gotWords[0], 32'h00000001);
            checkOutput("stall_w1", gotWords[1], 32'h00000003);
            checkOutput("stall_w2", gotWords[2], 32'h00000006);
        end

        $display("[TB] directed: abort on word 5 of 100");
        runBurst(32'hA5A5A5A5, 100, 100, 5, 0);
        checkOutput("abort_words", gotWords.size(), 5);
        runBurst(32'h0BADF00D, 3, 100, 3, 0);
        runBurst(32'hDEADBEEF, 65535, 100, 3, 0);

        $display("[TB] directed: abort while idle");
        applyStimulus(1'b0, 32'd0, '0, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("idle_abort_busy", busy, 0);
        checkOutput("idle_abort_done", done, 0);
        checkOutput("idle_abort_aborted", aborted, 0);
        applyStimulus(1'b0, 32'd0, '0, 1'b0, 1'b0);

        $display("[TB] directed: reset mid-burst");
        applyStimulus(1'b1, 32'hCAFEF00D, CNT_W'(50), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("mid_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'd0, '0, 1'b0, 1'b0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_data", out_data, 32'h00000001);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_done", done, 0);
            checkOutput("post_rst_valid", out_valid, 0);
        end

        $display("[TB] random bursts");
        for (int i = 0; i < 30; i++) begin
            seed    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            count   = $urandom_range(0, 20);
            pct     = $urandom_range(30, 100);
            abortAt = ($urandom_range(0, 2) == 0 && count > 0) ? $urandom_range(1, count) : 0;
            runBurst(seed, count, pct, abortAt, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
